// File: rtl/one_sixteen_demux.sv
// Registered 1-to-16 demux with one-deep per-lane hold registers. Latency 1; in_ready drops when the target lane (or, for broadcast, any lane) is full and not being acked.
// Optional ONE_SIXTEEN_RR_EN: unicast lane chosen by an internal round-robin pointer exposed on rr_ptr.
module one_sixteen_demux #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      in_data,
  input  logic [3:0]            in_sel,
  input  logic                  in_bcast,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [16*WIDTH-1:0]   out_data,
  output logic [15:0]           out_valid,
  input  logic [15:0]           out_ack,
  output logic [CNT_W-1:0]      acc_count
`ifdef ONE_SIXTEEN_RR_EN
  ,
  output logic [3:0]            rr_ptr
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } lane_state_t;

  lane_state_t      state_q [16];
  lane_state_t      state_d [16];
  logic [WIDTH-1:0] data_q  [16];
  logic [CNT_W-1:0] acc_q;
  logic [3:0]       dest;
  logic [15:0]      lane_free;
  logic [15:0]      wr;
  logic             accept;

`ifdef ONE_SIXTEEN_RR_EN
  logic [3:0] ptr_q;
  logic       rr_unused_sel;

  assign rr_unused_sel = ^in_sel;
  assign dest          = ptr_q;
  assign rr_ptr        = ptr_q;

  // Broadcasts leave the pointer alone so unicast order is not disturbed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 4'd0;
    end else if (accept && !in_bcast) begin
      ptr_q <= ptr_q + 4'd1;
    end
  end
`else
  assign dest = in_sel;
`endif

  // A lane being acked this cycle can take a new word on the same edge.
  assign lane_free = ~out_valid | out_ack;
  assign in_ready  = rst_n & (in_bcast ? (&lane_free) : lane_free[dest]);
  assign accept    = in_valid & in_ready;
  assign wr        = !accept ? 16'h0000 : (in_bcast ? 16'hFFFF : (16'h0001 << dest));

  always_comb begin
    for (int k = 0; k < 16; k++) begin
      state_d[k] = state_q[k];
      unique case (state_q[k])
        EMPTY: if (wr[k]) state_d[k] = FULL;
        FULL:  if (!wr[k] && out_ack[k]) state_d[k] = EMPTY;
        default: state_d[k] = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 16; k++) begin
        state_q[k] <= EMPTY;
      end
    end else begin
      for (int k = 0; k < 16; k++) begin
        state_q[k] <= state_d[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 16; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 16; k++) begin
        if (wr[k]) data_q[k] <= in_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (accept && (acc_q != {CNT_W{1'b1}})) begin
      acc_q <= acc_q + CNT_W'(1);
    end
  end

  assign acc_count = acc_q;

  for (genvar g = 0; g < 16; g++) begin : g_lane
    assign out_valid[g]                 = (state_q[g] == FULL);
    assign out_data[g*WIDTH +: WIDTH]   = data_q[g];

    // A held word must not move until its consumer takes it.
    a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
      (out_valid[g] && !out_ack[g]) |=> $stable(data_q[g]));
  end

endmodule

// File: tb/tb_one_sixteen_demux.sv
// Directed bench for one_sixteen_demux: vector table for single-cycle behaviour, hand sequences for streaming, saturation and reset.
// A second instance with a 3-bit counter exercises counter saturation cheaply.
module tb_one_sixteen_demux;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [15:0]        in_data;
  logic [3:0]         in_sel;
  logic               in_bcast;
  logic               in_valid;
  logic               in_ready;
  logic [255:0]       out_data;
  logic [15:0]        out_valid;
  logic [15:0]        out_ack;
  logic [15:0]        acc_count;
  logic               in_ready_s;
  logic [255:0]       out_data_s;
  logic [15:0]        out_valid_s;
  logic [2:0]         acc_s;
`ifdef ONE_SIXTEEN_RR_EN
  logic [3:0]         rr_ptr;
  logic [3:0]         rr_ptr_s;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  one_sixteen_demux #(.WIDTH(16), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel),
    .in_bcast(in_bcast), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ack(out_ack),
    .acc_count(acc_count)
`ifdef ONE_SIXTEEN_RR_EN
    , .rr_ptr(rr_ptr)
`endif
  );

  one_sixteen_demux #(.WIDTH(16), .CNT_W(3)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel),
    .in_bcast(in_bcast), .in_valid(in_valid), .in_ready(in_ready_s),
    .out_data(out_data_s), .out_valid(out_valid_s), .out_ack(out_ack),
    .acc_count(acc_s)
`ifdef ONE_SIXTEEN_RR_EN
    , .rr_ptr(rr_ptr_s)
`endif
  );

  typedef struct {
    logic        v;
    logic        b;
    logic [3:0]  s;
    logic [15:0] d;
    logic [15:0] ack;
    logic        rdy;
    logic [15:0] ov;
    int          lane;
    logic [15:0] ld;
    int          acc;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] lane(input int k);
    return out_data[k*16 +: 16];
  endfunction

  function automatic int sat7(input int a);
    return (a > 7) ? 7 : a;
  endfunction

  task automatic drive(input logic v, input logic b, input logic [3:0] s,
                       input logic [15:0] d, input logic [15:0] ack);
    in_valid = v; in_bcast = b; in_sel = s; in_data = d; out_ack = ack;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 4'd0, 16'h0, 16'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic apply(input vec_t t, input int idx);
    @(negedge clk);
    drive(t.v, t.b, t.s, t.d, t.ack);
    #1 chk($sformatf("v%0d_ready", idx), 64'(in_ready), 64'(t.rdy));
    @(posedge clk);
    #1;
    chk($sformatf("v%0d_valid", idx), 64'(out_valid), 64'(t.ov));
    chk($sformatf("v%0d_lane%0d", idx, t.lane), 64'(lane(t.lane)), 64'(t.ld));
    chk($sformatf("v%0d_acc", idx), 64'(acc_count), 64'(t.acc));
    chk($sformatf("v%0d_acc_sat", idx), 64'(acc_s), 64'(sat7(t.acc)));
  endtask

  task automatic midstream_reset();
    @(negedge clk);
    drive(1'b1, 1'b0, 4'd1, 16'h4444, 16'h0);
    @(negedge clk);
    drive(1'b1, 1'b0, 4'd2, 16'h5555, 16'h0);
    @(negedge clk);
    drive(1'b1, 1'b0, 4'd3, 16'h6666, 16'h0);
    chk("mid_pre_valid", 64'(out_valid != 16'h0), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'h0);
    chk("mid_rst_data", 64'(|out_data), 64'h0);
    chk("mid_rst_acc", 64'(acc_count), 64'h0);
    chk("mid_rst_ready", 64'(in_ready), 64'h0);
`ifdef ONE_SIXTEEN_RR_EN
    chk("mid_rst_ptr", 64'(rr_ptr), 64'h0);
`endif
    @(negedge clk);
    drive(1'b0, 1'b0, 4'd0, 16'h0, 16'h0);
    rst_n = 1'b1;
  endtask

  vec_t vt [10];

  initial begin
    vt[0] = '{1'b1, 1'b0, 4'd5, 16'hA5A5, 16'h0000, 1'b1, 16'h0020, 5,  16'hA5A5, 1};
    vt[1] = '{1'b1, 1'b0, 4'd5, 16'h1111, 16'h0000, 1'b0, 16'h0020, 5,  16'hA5A5, 1};
    vt[2] = '{1'b1, 1'b0, 4'd5, 16'h1234, 16'h0020, 1'b1, 16'h0020, 5,  16'h1234, 2};
    vt[3] = '{1'b1, 1'b0, 4'd3, 16'h3333, 16'h0000, 1'b1, 16'h0028, 3,  16'h3333, 3};
    vt[4] = '{1'b0, 1'b0, 4'd5, 16'h0000, 16'h0020, 1'b1, 16'h0008, 5,  16'h1234, 3};
    vt[5] = '{1'b1, 1'b1, 4'd0, 16'hBEEF, 16'h0000, 1'b0, 16'h0008, 3,  16'h3333, 3};
    vt[6] = '{1'b1, 1'b1, 4'd0, 16'hBEEF, 16'h0008, 1'b1, 16'hFFFF, 3,  16'hBEEF, 4};
    vt[7] = '{1'b1, 1'b0, 4'd9, 16'h9999, 16'hFFFF, 1'b1, 16'h0200, 9,  16'h9999, 5};
    vt[8] = '{1'b0, 1'b0, 4'd9, 16'h0000, 16'h0200, 1'b1, 16'h0000, 9,  16'h9999, 5};
    vt[9] = '{1'b0, 1'b0, 4'd0, 16'h0000, 16'h0001, 1'b1, 16'h0000, 0,  16'hBEEF, 5};

    rst_n = 1'b0;
    drive(1'b1, 1'b0, 4'd5, 16'hA5A5, 16'h0);
    #12;
    chk("rst_ready", 64'(in_ready), 64'h0);
    chk("rst_valid", 64'(out_valid), 64'h0);
    chk("rst_data", 64'(|out_data), 64'h0);
    chk("rst_acc", 64'(acc_count), 64'h0);
    @(negedge clk);
    drive(1'b0, 1'b0, 4'd0, 16'h0, 16'h0);
    rst_n = 1'b1;

`ifndef ONE_SIXTEEN_RR_EN
    for (int i = 0; i < 10; i++) apply(vt[i], i);
    for (int k = 0; k < 16; k++)
      chk($sformatf("bcast_lane%0d", k), 64'(lane(k)), (k == 9) ? 64'h9999 : 64'hBEEF);

    do_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive(1'b1, 1'b0, 4'd0, 16'h1000 + 16'(i), 16'h0001);
      #1 chk($sformatf("str%0d_ready", i), 64'(in_ready), 64'h1);
      @(posedge clk);
      #1;
      chk($sformatf("str%0d_valid", i), 64'(out_valid), 64'h0001);
      chk($sformatf("str%0d_data", i), 64'(lane(0)), 64'(16'h1000 + 16'(i)));
      chk($sformatf("str%0d_acc", i), 64'(acc_count), 64'(i + 1));
      chk($sformatf("str%0d_acc_sat", i), 64'(acc_s), 64'(sat7(i + 1)));
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 4'd0, 16'h0, 16'h0001);
    @(posedge clk);
    #1;
    chk("str_drain_valid", 64'(out_valid), 64'h0);
    chk("str_drain_data", 64'(lane(0)), 64'h1013);
    chk("str_drain_acc", 64'(acc_count), 64'd20);
`else
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(1'b1, 1'b0, 4'd7, 16'h2000 + 16'(i), 16'h0);
      #1 chk($sformatf("rr%0d_ready", i), 64'(in_ready), 64'h1);
      @(posedge clk);
      #1;
      chk($sformatf("rr%0d_valid", i), 64'(out_valid), 64'(16'((32'd1 << (i + 1)) - 1)));
      chk($sformatf("rr%0d_lane", i), 64'(lane(i)), 64'(16'h2000 + 16'(i)));
      chk($sformatf("rr%0d_ptr", i), 64'(rr_ptr), 64'((i + 1) % 16));
    end
    @(negedge clk);
    drive(1'b1, 1'b0, 4'd7, 16'h2010, 16'h0);
    #1 chk("rr16_stall_ready", 64'(in_ready), 64'h0);
    @(negedge clk);
    drive(1'b1, 1'b0, 4'd7, 16'h2010, 16'h0001);
    #1 chk("rr16_ack_ready", 64'(in_ready), 64'h1);
    @(posedge clk);
    #1;
    chk("rr16_lane0", 64'(lane(0)), 64'h2010);
    chk("rr16_valid", 64'(out_valid), 64'hFFFF);
    chk("rr16_ptr", 64'(rr_ptr), 64'h1);
    chk("rr16_acc", 64'(acc_count), 64'd17);
    @(negedge clk);
    drive(1'b1, 1'b1, 4'd0, 16'h7777, 16'hFFFF);
    @(posedge clk);
    #1;
    chk("rr_bcast_ptr", 64'(rr_ptr), 64'h1);
    chk("rr_bcast_lane15", 64'(lane(15)), 64'h7777);
`endif

    midstream_reset();
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/one_sixteen_demux.md
Name: one_sixteen_demux

Overview:
- Registered 1-to-16 demultiplexer. Steers a valid/ready input word stream to one of 16 output lanes, or to all 16 lanes at once.
- Each lane has a one-deep hold register with a valid/ack handshake toward its consumer.
- It is the distribution end of the datapath whose 16:1 mux gathers lanes back into one stream.
- Also keeps a saturating count of accepted words for lab debug.

Parameters:
- WIDTH, 16, data width of each lane in bits.
- CNT_W, 16, width of the accepted-word counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  WIDTH  word to distribute.
- in_sel  input  4  destination lane index, 0..15.
- in_bcast  input  1  when 1, the word goes to all 16 lanes and in_sel is ignored.
- in_valid  input  1  source offers a word.
- in_ready  output  1  block accepts this cycle (combinational).
- out_data  output  16*WIDTH  lane k occupies bits [k*WIDTH +: WIDTH].
- out_valid  output  16  lane k hold register is full.
- out_ack  input  16  consumer k takes its word this cycle.
- acc_count  output  CNT_W  words accepted since reset; saturates.

Behaviour:
- Reset (async assert, sync-released by the environment):
  - out_valid = 0, out_data = 0, acc_count = 0.
  - Internal pointer = 0 (see Optional Feature).
  - in_ready = 0 while rst_n is low.
- Lane k is free when out_valid[k]=0 or out_ack[k]=1.
- in_ready:
  - Unicast: in_ready = lane in_sel free.
  - Broadcast: in_ready = all 16 lanes free.
- Accept = in_valid & in_ready. Sampled at the rising edge; takes effect the next cycle (latency 1).
- Lane update per edge, for each k:
  - If written by the accept: out_data[k] <= in_data and out_valid[k] <= 1. This applies even if out_ack[k]=1 in the same cycle; ack and new write coexist, giving back-to-back throughput of 1 word/cycle per lane.
  - Else if out_ack[k]=1: out_valid[k] <= 0; out_data[k] holds its value.
  - out_ack[k] with out_valid[k]=0 is ignored.
- Data stability: out_data[k] does not change while out_valid[k]=1 and out_ack[k]=0.
- Source side: in_valid may drop without acceptance (no source-side stickiness required). in_data and in_sel are don't-care when in_valid=0.
- acc_count:
  - +1 per accept; a broadcast counts as 1.
  - Saturates at 2^CNT_W-1, no wrap.
- Per-lane state machine: EMPTY -> FULL on write; FULL -> EMPTY on ack without write; FULL -> FULL on write or on hold.
- Broadcast while any lane is FULL and un-acked: stall (in_ready=0), no partial write.
- Reset asserted mid-transfer: all lanes drop to EMPTY immediately and in-flight words are lost.

Optional Feature:
- Macro: ONE_SIXTEEN_RR_EN.
- Defined:
  - in_sel is ignored for unicast.
  - Destination is an internal 4-bit round-robin pointer, reset 0.
  - Pointer increments mod 16 after each unicast accept (15 -> 0 wraps).
  - Broadcast does not move the pointer.
  - Extra output rr_ptr (4 bits) exposes the pointer.
- Undefined: in_sel addresses the lane; no pointer logic and no rr_ptr port.

Test Plan:
- Reset, then in_valid=1, in_sel=5, in_data=16'hA5A5 -> in_ready=1; next cycle out_valid=16'h0020 and lane5 data=16'hA5A5; acc_count=1.
- Lane 5 FULL, out_ack=0, second word to sel=5 -> in_ready=0 and lane5 keeps 16'hA5A5. Then assert out_ack[5] the same cycle as the word 16'h1234 -> accepted; next cycle out_valid[5]=1, data=16'h1234.
- Broadcast 16'hBEEF with lane 3 FULL and un-acked -> in_ready=0, no lane changes. Ack lane 3 -> accept; all 16 lanes read 16'hBEEF and out_valid=16'hFFFF.
- Continuous unicast to sel=0 with out_ack[0]=1 every cycle, 20 words -> 1 word/cycle, data sequence preserved, acc_count=20.
- Force acc_count to 16'hFFFE, accept 3 words -> acc_count reads 16'hFFFF and stays.
- ONE_SIXTEEN_RR_EN defined: 17 unicast words with in_sel=7 throughout -> lanes 0..15 written in order, the 17th wraps to lane 0 (after lane 0 is acked), rr_ptr=1. Assert rst_n low mid-stream -> out_valid=0 and rr_ptr=0 immediately.
